// File: rtl/ppwm_cfg_pkg.sv
// ppwm_cfg_pkg: shared types and constants for the PWM configuration controller.
//   cmd_e    : header command field encoding
//   state_e  : byte-deframer FSM states
//   min_u8   : unsigned 8-bit minimum used by the duty clamp
package ppwm_cfg_pkg;

  localparam int NUM_CH_DEF  = 4;
  localparam int TIMEOUT_DEF = 255;

  localparam logic [7:0] RST_PERIOD = 8'hFF;
  localparam logic [7:0] RST_DUTY   = 8'h00;

  typedef enum logic [1:0] {
    CMD_NOP    = 2'b00,
    CMD_DUTY   = 2'b01,
    CMD_PERIOD = 2'b10,
    CMD_ENMASK = 2'b11
  } cmd_e;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_e;

  function automatic logic [7:0] min_u8(input logic [7:0] a, input logic [7:0] b);
    if (a < b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/ppwm_cfg_ctrl_if.sv
// ppwm_cfg_ctrl_if: byte-wide valid/ready configuration channel.
//   cfg_data  : configuration byte (header or payload)
//   cfg_valid : cfg_data is valid this cycle
//   cfg_ready : receiver can take a byte; transfer when valid && ready
interface ppwm_cfg_ctrl_if;

  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);

endinterface

// File: rtl/ppwm_cfg_regbank.sv
// ppwm_cfg_regbank: shadow/active double buffer for per-channel period, duty
// and enable mask. Writes land in shadow; a commit copies shadow to active,
// clamping duty to period.
//   clk, rst   : clock, async active-high reset
//   wr_en      : payload write strobe
//   wr_cmd     : command selecting the shadow target
//   wr_ch      : channel index for DUTY/PERIOD
//   wr_data    : payload byte
//   commit     : period_end pulse
//   period_o, duty_o, ch_en_o : active values
//   pending_o  : shadow holds values not yet committed
module ppwm_cfg_regbank
  import ppwm_cfg_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  cmd_e                  wr_cmd,
  input  logic [1:0]            wr_ch,
  input  logic [7:0]            wr_data,
  input  logic                  commit,
  output logic [8*NUM_CH-1:0]   period_o,
  output logic [8*NUM_CH-1:0]   duty_o,
  output logic [NUM_CH-1:0]     ch_en_o,
  output logic                  pending_o
);

  logic [7:0]        sh_period_r [NUM_CH];
  logic [7:0]        sh_duty_r   [NUM_CH];
  logic [NUM_CH-1:0] sh_en_r;
  logic [7:0]        sh_period_s [NUM_CH];
  logic [7:0]        sh_duty_s   [NUM_CH];
  logic [NUM_CH-1:0] sh_en_s;
  logic [7:0]        act_period_r [NUM_CH];
  logic [7:0]        act_duty_r   [NUM_CH];
  logic [NUM_CH-1:0] act_en_r;
  logic              pending_r;
  logic              commit_s;

  // A payload arriving with the commit pulse must be part of that commit.
  assign commit_s = commit & (pending_r | wr_en);

  // Next shadow contents including any payload written this cycle.
  always_comb begin
    sh_period_s = sh_period_r;
    sh_duty_s   = sh_duty_r;
    sh_en_s     = sh_en_r;
    if (wr_en) begin
      case (wr_cmd)
        CMD_DUTY:   sh_duty_s[wr_ch]   = wr_data;
        CMD_PERIOD: sh_period_s[wr_ch] = wr_data;
        CMD_ENMASK: sh_en_s            = wr_data[NUM_CH-1:0];
        default:    sh_en_s            = sh_en_r;
      endcase
    end else begin
      sh_en_s = sh_en_r;
    end
  end

  // Shadow register update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_CH; n++) begin
        sh_period_r[n] <= RST_PERIOD;
        sh_duty_r[n]   <= RST_DUTY;
      end
      sh_en_r <= '0;
    end else begin
      sh_period_r <= sh_period_s;
      sh_duty_r   <= sh_duty_s;
      sh_en_r     <= sh_en_s;
    end
  end

  // Active registers load from shadow on commit with duty clamped to period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_CH; n++) begin
        act_period_r[n] <= RST_PERIOD;
        act_duty_r[n]   <= RST_DUTY;
      end
      act_en_r <= '0;
    end else if (commit_s) begin
      for (int n = 0; n < NUM_CH; n++) begin
        act_period_r[n] <= sh_period_s[n];
        act_duty_r[n]   <= min_u8(sh_duty_s[n], sh_period_s[n]);
      end
      act_en_r <= sh_en_s;
    end else begin
      act_en_r <= act_en_r;
    end
  end

  // Pending flag: set by a payload write, cleared by a commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= 1'b0;
    end else if (commit_s) begin
      pending_r <= 1'b0;
    end else if (wr_en) begin
      pending_r <= 1'b1;
    end else begin
      pending_r <= pending_r;
    end
  end

  // Pack active per-channel bytes onto the output buses.
  always_comb begin
    period_o = '0;
    duty_o   = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      period_o[8*n +: 8] = act_period_r[n];
      duty_o[8*n +: 8]   = act_duty_r[n];
    end
  end

  assign ch_en_o   = act_en_r;
  assign pending_o = pending_r;

endmodule

// File: rtl/ppwm_cfg_ctrl.sv
// ppwm_cfg_ctrl: deframes header/payload byte pairs from the config channel,
// stages them in the register bank and commits on period_end.
//   clk, rst   : clock, async active-high reset
//   ena        : block enable; gates cfg_ready
//   cfg        : byte channel (slave side)
//   period_end : commit pulse from the PWM core
//   period_o, duty_o, ch_en_o, pending_o : register bank outputs
//   cfg_err    : sticky protocol error (payload timeout); cleared by NOP arg F
module ppwm_cfg_ctrl
  import ppwm_cfg_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  ppwm_cfg_ctrl_if.slave      cfg,
  input  logic                period_end,
  output logic [8*NUM_CH-1:0] period_o,
  output logic [8*NUM_CH-1:0] duty_o,
  output logic [NUM_CH-1:0]   ch_en_o,
  output logic                pending_o,
  output logic                cfg_err
);

  // The TIMEOUT-th consecutive idle cycle is the one seen with this count.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_e     state_r;
  cmd_e       cmd_r;
  logic [1:0] ch_r;
  logic [7:0] to_cnt_r;
  logic       cfg_err_r;
  logic       accept_s;
  logic       wr_en_s;
  cmd_e       hdr_cmd_s;

  assign cfg.cfg_ready = ena & ~rst;
  assign accept_s      = cfg.cfg_valid & ena & ~rst;
  assign hdr_cmd_s     = cmd_e'(cfg.cfg_data[7:6]);
  assign wr_en_s       = accept_s & (state_r == ST_PAYLOAD);
  assign cfg_err       = cfg_err_r;

  // Header/payload FSM with payload timeout and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cmd_r     <= CMD_NOP;
      ch_r      <= 2'd0;
      to_cnt_r  <= 8'd0;
      cfg_err_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          to_cnt_r <= 8'd0;
          if (accept_s && (hdr_cmd_s != CMD_NOP)) begin
            state_r <= ST_PAYLOAD;
            cmd_r   <= hdr_cmd_s;
            ch_r    <= cfg.cfg_data[5:4];
          end else if (accept_s && (cfg.cfg_data[3:0] == 4'hF)) begin
            cfg_err_r <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_PAYLOAD: begin
          if (accept_s) begin
            state_r  <= ST_IDLE;
            to_cnt_r <= 8'd0;
          end else if (!ena) begin
            // Losing enable abandons the frame silently.
            state_r  <= ST_IDLE;
            to_cnt_r <= 8'd0;
          end else if (to_cnt_r == TO_LAST) begin
            state_r   <= ST_IDLE;
            to_cnt_r  <= 8'd0;
            cfg_err_r <= 1'b1;
          end else begin
            to_cnt_r <= to_cnt_r + 8'd1;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          to_cnt_r <= 8'd0;
        end
      endcase
    end
  end

  ppwm_cfg_regbank #(
    .NUM_CH (NUM_CH)
  ) u_regbank (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en_s),
    .wr_cmd    (cmd_r),
    .wr_ch     (ch_r),
    .wr_data   (cfg.cfg_data),
    .commit    (period_end),
    .period_o  (period_o),
    .duty_o    (duty_o),
    .ch_en_o   (ch_en_o),
    .pending_o (pending_o)
  );

endmodule

// File: tb/tb_ppwm_cfg_ctrl.sv
module tb_ppwm_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        period_end;
  logic [31:0] period_o;
  logic [31:0] duty_o;
  logic [3:0]  ch_en_o;
  logic        pending_o;
  logic        cfg_err;

  ppwm_cfg_ctrl_if cfg_if ();

  ppwm_cfg_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .cfg        (cfg_if),
    .period_end (period_end),
    .period_o   (period_o),
    .duty_o     (duty_o),
    .ch_en_o    (ch_en_o),
    .pending_o  (pending_o),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] period;
    logic [31:0] duty;
    logic [3:0]  en;
    logic        pend;
    logic        err;
    logic        ready;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  logic chk_req  = 1'b0;

  // Hand-maintained expected outputs.
  logic [31:0] e_period;
  logic [31:0] e_duty;
  logic [3:0]  e_en;
  logic        e_pend;
  logic        e_err;
  logic        e_ready;

  task automatic cmp(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
    end
  endtask

  // Monitor: pops one expected snapshot whenever a check is requested.
  always @(negedge clk) begin
    if (chk_req) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard_underflow actual=empty required=entry");
      end else begin
        mon_e = exp_q.pop_front();
        cmp(mon_e.name, "period_o",  period_o,              mon_e.period);
        cmp(mon_e.name, "duty_o",    duty_o,                mon_e.duty);
        cmp(mon_e.name, "ch_en_o",   {28'd0, ch_en_o},      {28'd0, mon_e.en});
        cmp(mon_e.name, "pending_o", {31'd0, pending_o},    {31'd0, mon_e.pend});
        cmp(mon_e.name, "cfg_err",   {31'd0, cfg_err},      {31'd0, mon_e.err});
        cmp(mon_e.name, "cfg_ready", {31'd0, cfg_if.cfg_ready}, {31'd0, mon_e.ready});
      end
    end
  end

  task automatic check_state(input string nm);
    exp_t e;
    e.name   = nm;
    e.period = e_period;
    e.duty   = e_duty;
    e.en     = e_en;
    e.pend   = e_pend;
    e.err    = e_err;
    e.ready  = e_ready;
    exp_q.push_back(e);
    chk_req = 1'b1;
    @(negedge clk);
    #1;
    chk_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    cfg_if.cfg_data  = b;
    cfg_if.cfg_valid = 1'b1;
    @(posedge clk);
    #1;
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic pulse_pe();
    period_end = 1'b1;
    @(posedge clk);
    #1;
    period_end = 1'b0;
  endtask

  task automatic set_reset_exp();
    e_period = 32'hFFFF_FFFF;
    e_duty   = 32'h0000_0000;
    e_en     = 4'h0;
    e_pend   = 1'b0;
    e_err    = 1'b0;
    e_ready  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    ena = 1'b0;
    period_end = 1'b0;
    cfg_if.cfg_data  = 8'h00;
    cfg_if.cfg_valid = 1'b0;
    set_reset_exp();
    repeat (3) @(posedge clk);
    #1;
    check_state("reset");
    rst = 1'b0;
    ena = 1'b1;
    e_ready = 1'b1;
    check_state("post_reset");

    // DUTY ch1 = 0x40, commit.
    send_byte(8'h50);
    send_byte(8'h40);
    e_pend = 1'b1;
    check_state("t1_staged");
    pulse_pe();
    e_duty = 32'h0000_4000;
    e_pend = 1'b0;
    check_state("t1_commit");

    // PERIOD ch0 = 0x20, DUTY ch0 = 0x80 -> clamped to 0x20.
    send_byte(8'h80);
    send_byte(8'h20);
    send_byte(8'h40);
    send_byte(8'h80);
    e_pend = 1'b1;
    check_state("t2_staged");
    pulse_pe();
    e_period = 32'hFFFF_FF20;
    e_duty   = 32'h0000_4020;
    e_pend   = 1'b0;
    check_state("t2_clamp");

    // ENMASK payload accepted in the same cycle as period_end.
    send_byte(8'hC0);
    cfg_if.cfg_data  = 8'h05;
    cfg_if.cfg_valid = 1'b1;
    period_end       = 1'b1;
    @(posedge clk);
    #1;
    cfg_if.cfg_valid = 1'b0;
    period_end       = 1'b0;
    e_en = 4'h5;
    check_state("t3_same_cycle");
    pulse_pe();
    check_state("t3_idle_commit");

    // Payload timeout after a PERIOD header.
    send_byte(8'h80);
    repeat (254) @(posedge clk);
    #1;
    check_state("t4_before_timeout");
    @(posedge clk);
    #1;
    e_err = 1'b1;
    check_state("t4_timeout");
    send_byte(8'h00);
    check_state("t4_sticky");
    send_byte(8'h0F);
    e_err = 1'b0;
    check_state("t4_clear");

    // Enable drop mid-frame keeps staged data.
    send_byte(8'h60);
    send_byte(8'h10);
    e_pend = 1'b1;
    check_state("t5_staged");
    send_byte(8'h70);
    ena = 1'b0;
    e_ready = 1'b0;
    check_state("t5_ena_low");
    @(posedge clk);
    #1;
    ena = 1'b1;
    e_ready = 1'b1;
    send_byte(8'h0F);
    check_state("t5_resume");
    pulse_pe();
    e_duty = 32'h0010_4020;
    e_pend = 1'b0;
    check_state("t5_commit");

    // Reset mid-frame, then header decoding and commit with ena low.
    send_byte(8'h60);
    rst = 1'b1;
    set_reset_exp();
    check_state("t6_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    e_ready = 1'b1;
    send_byte(8'h50);
    check_state("t6_header");
    send_byte(8'h77);
    e_pend = 1'b1;
    check_state("t6_staged");
    ena = 1'b0;
    e_ready = 1'b0;
    pulse_pe();
    e_duty = 32'h0000_7700;
    e_pend = 1'b0;
    check_state("t6_commit_ena_low");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ppwm_cfg_ctrl.md
PPWM_CFG_CTRL -- requirements
Module: ppwm_cfg_ctrl

Interface
REQ-001 Parameter NUM_CH, default 4, SHALL set the number of PWM channels configured (fixed at 4 for this tapeout).
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum idle cycles allowed between a header byte and its payload byte.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-005 ena  in  1  SHALL be the block enable; low means no bytes are accepted.
REQ-006 cfg_data  in  8  SHALL carry the configuration byte.
REQ-007 cfg_valid  in  1  SHALL mark cfg_data as valid this cycle.
REQ-008 cfg_ready  out  1  SHALL indicate that a byte can be accepted; transfer occurs when cfg_valid and cfg_ready are both high.
REQ-009 period_end  in  1  SHALL be a one-cycle pulse from the PWM core marking the end of a PWM period (commit point).
REQ-010 period_o  out  8*NUM_CH  SHALL be the active per-channel period, channel n at bits [8n+7:8n].
REQ-011 duty_o  out  8*NUM_CH  SHALL be the active per-channel duty, with the same packing as period_o.
REQ-012 ch_en_o  out  NUM_CH  SHALL be the active channel-enable mask.
REQ-013 pending_o  out  1  SHALL be high while staged values await commit.
REQ-014 cfg_err  out  1  SHALL be the sticky protocol-error flag.

Function
REQ-015 cfg_ready SHALL equal ena when no reset is active; no other condition stalls it.
REQ-016 Header byte format SHALL be {cmd[7:6], ch[5:4], arg[3:0]}; cmd 00=NOP, 01=DUTY, 10=PERIOD, 11=ENMASK.
REQ-017 FSM states SHALL be IDLE and PAYLOAD, with the following transitions.
- IDLE: an accepted header with cmd!=NOP goes to PAYLOAD. NOP stays in IDLE, and NOP with arg=4'hF clears cfg_err.
- PAYLOAD: the next accepted byte is the payload and returns to IDLE.
REQ-018 Payload handling SHALL write only the shadow registers.
- DUTY: payload goes to shadow duty[ch].
- PERIOD: payload goes to shadow period[ch].
- ENMASK: payload[NUM_CH-1:0] goes to shadow enable; ch is ignored.
- Every payload write sets pending.
REQ-019 On a period_end pulse with pending set, all active registers SHALL load from shadow on the same edge and pending SHALL clear; the outputs change the cycle after the pulse.
REQ-020 When a payload is accepted in the same cycle as period_end, that payload SHALL be included in the commit and pending SHALL end low.
REQ-021 Commit SHALL clamp duty: active duty[n] = min(shadow duty[n], shadow period[n]), using an unsigned 8-bit compare.
REQ-022 A period_end pulse with pending low SHALL leave all outputs unchanged.
REQ-023 Timeout: in PAYLOAD, an 8-bit counter SHALL count cycles without an accepted byte.
- Reaching TIMEOUT returns the FSM to IDLE and sets cfg_err.
- The partial frame is discarded and the shadow registers are unchanged.
REQ-024 ena falling while in PAYLOAD SHALL return the FSM to IDLE without setting cfg_err; shadow, active and pending SHALL be kept.
REQ-025 Commits SHALL occur regardless of ena.

Reset
REQ-026 While rst is high, all of the following SHALL hold:
- active and shadow period = 8'hFF, duty = 8'h00, enable = 0;
- pending_o = 0, cfg_err = 0, cfg_ready = 0;
- FSM = IDLE, timeout counter = 0.
REQ-027 Reset asserted mid-frame SHALL discard the frame; the first accepted byte after release SHALL be treated as a header.

Structure
REQ-028 Package ppwm_cfg_pkg SHALL hold the cmd enum, the FSM state enum, NUM_CH/TIMEOUT defaults and the reset constants (8'hFF, 8'h00).
REQ-029 Shadow/active double-buffer storage and the clamp-on-commit logic SHALL live in sub-module ppwm_cfg_regbank; the FSM and timeout counter SHALL stay in ppwm_cfg_ctrl.

Verification
REQ-030 Send header 8'h50, payload 8'h40, then period_end -> duty_o[15:8]=8'h40 the cycle after the pulse, pending_o 1->0.
REQ-031 Send PERIOD ch0 = 8'h20, DUTY ch0 = 8'h80, then period_end -> period_o[7:0]=8'h20, duty_o[7:0]=8'h20 (clamped).
REQ-032 Accept ENMASK payload 8'h05 in the same cycle as period_end -> ch_en_o=4'b0101 the next cycle, pending_o=0.
REQ-033 Send header 8'h80, then hold cfg_valid low for 255 cycles -> cfg_err=1 and FSM in IDLE; then send 8'h0F -> cfg_err=0.
REQ-034 Assert rst mid-frame after header 8'h60 -> all outputs at reset values; after release, byte 8'h50 is decoded as a header.
REQ-035 Drop ena during PAYLOAD -> cfg_ready=0, FSM in IDLE, cfg_err=0; previously staged pending_o is retained and commits on the next period_end.
